// File: rtl/bus_arbiter_pkg.sv
// Shared types for bus_arbiter: FSM state, requester ids and the
// requester count. Optional feature macro: BUS_ARBITER_ROUND_ROBIN_EN.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        IR = 2'd0,
        DR = 2'd1,
        DW = 2'd2
    } req_id_t;

    localparam int unsigned NUM_REQ = 3;

    // Encode a one-hot grant vector as a requester id (IR when empty)
    function automatic req_id_t onehot_to_id(input logic [NUM_REQ-1:0] oh);
        req_id_t id;
        id = IR;
        if (oh[DW]) begin
            id = DW;
        end else if (oh[DR]) begin
            id = DR;
        end
        return id;
    endfunction

endpackage

// File: rtl/arb_picker.sv
// Combinational winner selection for bus_arbiter.
// BUS_ARBITER_ROUND_ROBIN_EN defined: round-robin starting one past ptr.
// Undefined: fixed priority DW > DR > IR, ptr ignored.
module arb_picker
    import bus_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            ptr,
    output logic [NUM_REQ-1:0] grant
);

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    logic       found;
    logic [1:0] idx;

    // Scan requesters starting one past the previous winner, wrapping mod 3
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 2'd0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 2'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Fixed priority: data write first, then data read, then instruction read
    always_comb begin
        grant = '0;
        if (req[DW]) begin
            grant[DW] = 1'b1;
        end else if (req[DR]) begin
            grant[DR] = 1'b1;
        end else if (req[IR]) begin
            grant[IR] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Shares one memory request/response port between the CPU's instruction
// read, data read and data write channels; one transaction in flight.
// Optional feature macro: BUS_ARBITER_ROUND_ROBIN_EN (round-robin picking
// instead of fixed DW > DR > IR priority).
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int RESP_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ir_addr_valid,
    output logic                  ir_addr_ready,
    input  logic [ADDR_WIDTH-1:0] ir_addr,
    output logic                  ir_data_valid,
    input  logic                  ir_data_ready,
    output logic [DATA_WIDTH-1:0] ir_data,

    input  logic                  dr_addr_valid,
    output logic                  dr_addr_ready,
    input  logic [ADDR_WIDTH-1:0] dr_addr,
    output logic                  dr_data_valid,
    input  logic                  dr_data_ready,
    output logic [DATA_WIDTH-1:0] dr_data,

    input  logic                  dw_data_addr_valid,
    output logic                  dw_data_addr_ready,
    input  logic [DATA_WIDTH-1:0] dw_data,
    input  logic [ADDR_WIDTH-1:0] dw_addr,
    input  logic [STRB_WIDTH-1:0] dw_strobe,
    output logic                  dw_resp_valid,
    input  logic                  dw_resp_ready,
    output logic [RESP_WIDTH-1:0] dw_resp,

    output logic                  m_req_valid,
    input  logic                  m_req_ready,
    output logic [ADDR_WIDTH-1:0] m_req_addr,
    output logic                  m_req_we,
    output logic [DATA_WIDTH-1:0] m_req_wdata,
    output logic [STRB_WIDTH-1:0] m_req_strobe,

    input  logic                  m_rsp_valid,
    output logic                  m_rsp_ready,
    input  logic [DATA_WIDTH-1:0] m_rsp_rdata,
    input  logic [RESP_WIDTH-1:0] m_rsp_resp
);

    state_t             state;
    req_id_t            grant_id;
    req_id_t            pick_ptr;
    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] accept;
    logic               grant_rsp_ready;
    logic               in_resp;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    req_id_t            last_grant;
    assign pick_ptr = last_grant;
`else
    assign pick_ptr = DW;
`endif

    assign req_vec = {dw_data_addr_valid, dr_addr_valid, ir_addr_valid};

    arb_picker u_picker (
        .req   (req_vec),
        .ptr   (pick_ptr),
        .grant (pick)
    );

    // Upstream ready is offered only in IDLE and is held low while reset is asserted
    assign accept = (state == IDLE && !rst) ? pick : '0;

    assign ir_addr_ready      = accept[IR];
    assign dr_addr_ready      = accept[DR];
    assign dw_data_addr_ready = accept[DW];

    // Select the granted channel's upstream response ready
    always_comb begin
        grant_rsp_ready = 1'b0;
        case (grant_id)
            IR:      grant_rsp_ready = ir_data_ready;
            DR:      grant_rsp_ready = dr_data_ready;
            DW:      grant_rsp_ready = dw_resp_ready;
            default: grant_rsp_ready = 1'b0;
        endcase
    end

    assign in_resp       = (state == RESP);
    assign m_rsp_ready   = in_resp && grant_rsp_ready;
    assign ir_data_valid = in_resp && (grant_id == IR) && m_rsp_valid;
    assign dr_data_valid = in_resp && (grant_id == DR) && m_rsp_valid;
    assign dw_resp_valid = in_resp && (grant_id == DW) && m_rsp_valid;

    assign ir_data = m_rsp_rdata;
    assign dr_data = m_rsp_rdata;
    assign dw_resp = m_rsp_resp;

    // Transaction FSM: capture the winner in IDLE, replay it in REQ, route the reply in RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            grant_id     <= IR;
            m_req_valid  <= 1'b0;
            m_req_addr   <= '0;
            m_req_we     <= 1'b0;
            m_req_wdata  <= '0;
            m_req_strobe <= '0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
            last_grant   <= DW;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|accept) begin
                        state       <= REQ;
                        m_req_valid <= 1'b1;
                        grant_id    <= onehot_to_id(accept);
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
                        last_grant  <= onehot_to_id(accept);
`endif
                        if (accept[DW]) begin
                            m_req_addr   <= dw_addr;
                            m_req_we     <= 1'b1;
                            m_req_wdata  <= dw_data;
                            m_req_strobe <= dw_strobe;
                        end else begin
                            m_req_addr   <= accept[DR] ? dr_addr : ir_addr;
                            m_req_we     <= 1'b0;
                            m_req_wdata  <= '0;
                            m_req_strobe <= '0;
                        end
                    end
                end
                REQ: begin
                    if (m_req_ready) begin
                        state       <= RESP;
                        m_req_valid <= 1'b0;
                    end
                end
                RESP: begin
                    if (m_rsp_valid && m_rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    m_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter. Build with or without
// BUS_ARBITER_ROUND_ROBIN_EN; the reference model follows the same macro.
module tb_bus_arbiter;

    localparam int AW = 32;
    localparam int DWID = 32;
    localparam int SW = 4;
    localparam int RW = 1;

    logic            clk;
    logic            rst;
    logic            ir_addr_valid, ir_addr_ready, ir_data_valid, ir_data_ready;
    logic [AW-1:0]   ir_addr;
    logic [DWID-1:0] ir_data;
    logic            dr_addr_valid, dr_addr_ready, dr_data_valid, dr_data_ready;
    logic [AW-1:0]   dr_addr;
    logic [DWID-1:0] dr_data;
    logic            dw_data_addr_valid, dw_data_addr_ready, dw_resp_valid, dw_resp_ready;
    logic [DWID-1:0] dw_data;
    logic [AW-1:0]   dw_addr;
    logic [SW-1:0]   dw_strobe;
    logic [RW-1:0]   dw_resp;
    logic            m_req_valid, m_req_ready, m_req_we;
    logic [AW-1:0]   m_req_addr;
    logic [DWID-1:0] m_req_wdata;
    logic [SW-1:0]   m_req_strobe;
    logic            m_rsp_valid, m_rsp_ready;
    logic [DWID-1:0] m_rsp_rdata;
    logic [RW-1:0]   m_rsp_resp;

    bus_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DWID),
        .STRB_WIDTH (SW),
        .RESP_WIDTH (RW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .ir_addr_valid      (ir_addr_valid),
        .ir_addr_ready      (ir_addr_ready),
        .ir_addr            (ir_addr),
        .ir_data_valid      (ir_data_valid),
        .ir_data_ready      (ir_data_ready),
        .ir_data            (ir_data),
        .dr_addr_valid      (dr_addr_valid),
        .dr_addr_ready      (dr_addr_ready),
        .dr_addr            (dr_addr),
        .dr_data_valid      (dr_data_valid),
        .dr_data_ready      (dr_data_ready),
        .dr_data            (dr_data),
        .dw_data_addr_valid (dw_data_addr_valid),
        .dw_data_addr_ready (dw_data_addr_ready),
        .dw_data            (dw_data),
        .dw_addr            (dw_addr),
        .dw_strobe          (dw_strobe),
        .dw_resp_valid      (dw_resp_valid),
        .dw_resp_ready      (dw_resp_ready),
        .dw_resp            (dw_resp),
        .m_req_valid        (m_req_valid),
        .m_req_ready        (m_req_ready),
        .m_req_addr         (m_req_addr),
        .m_req_we           (m_req_we),
        .m_req_wdata        (m_req_wdata),
        .m_req_strobe       (m_req_strobe),
        .m_rsp_valid        (m_rsp_valid),
        .m_rsp_ready        (m_rsp_ready),
        .m_rsp_rdata        (m_rsp_rdata),
        .m_rsp_resp         (m_rsp_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  strobe;
        logic [31:0] rdata;
        logic        resp;
    } txn_t;

    txn_t       slot [3];
    logic [1:0] acc_q [$];
    txn_t       req_q [$];
    txn_t       rsp_q [$];

    int n_checks = 0;
    int n_pass   = 0;
    bit mem_auto = 1'b1;
    bit rdy_auto = 1'b1;
    int force_stall = 5;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    int model_last = 2;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory contents as seen by the bench's memory model
    function automatic logic [31:0] mem_rdata(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'h0000_0013 : {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic mem_resp(input logic [31:0] a);
        return a[2];
    endfunction

    task automatic set_slot(input logic [1:0] c, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] st);
        slot[c].ch     = c;
        slot[c].addr   = a;
        slot[c].we     = (c == 2'd2);
        slot[c].wdata  = (c == 2'd2) ? wd : 32'h0;
        slot[c].strobe = (c == 2'd2) ? st : 4'h0;
        slot[c].rdata  = mem_rdata(a);
        slot[c].resp   = mem_resp(a);
        case (c)
            2'd0:    ir_addr = a;
            2'd1:    dr_addr = a;
            default: begin dw_addr = a; dw_data = wd; dw_strobe = st; end
        endcase
    endtask

    // Reference model: order in which a set of simultaneous requests gets served
    task automatic model_push(input logic [2:0] mask);
        logic [2:0] pend;
        logic [1:0] c;
        pend = mask;
        while (pend != 3'b000) begin
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
            c = 2'(model_last);
            do c = (c == 2'd2) ? 2'd0 : c + 2'd1; while (!pend[c]);
            model_last = int'(c);
`else
            c = pend[2] ? 2'd2 : (pend[1] ? 2'd1 : 2'd0);
`endif
            pend[c] = 1'b0;
            acc_q.push_back(c);
            req_q.push_back(slot[c]);
            rsp_q.push_back(slot[c]);
        end
    endtask

    task automatic wait_drain(input string name);
        int budget;
        budget = 0;
        while (rsp_q.size() != 0 && budget < 400) begin
            @(posedge clk); #1;
            budget++;
        end
        check(name, 64'(rsp_q.size()), 64'd0);
    endtask

    task automatic run_batch(input logic [2:0] mask);
        logic [2:0] pend;
        logic [2:0] acc;
        int budget;
        model_push(mask);
        ir_addr_valid      = mask[0];
        dr_addr_valid      = mask[1];
        dw_data_addr_valid = mask[2];
        pend   = mask;
        budget = 0;
        while (pend != 3'b000 && budget < 400) begin
            @(negedge clk);
            acc = {dw_data_addr_ready & dw_data_addr_valid,
                   dr_addr_ready & dr_addr_valid,
                   ir_addr_ready & ir_addr_valid};
            @(posedge clk); #1;
            if (acc[0]) ir_addr_valid = 1'b0;
            if (acc[1]) dr_addr_valid = 1'b0;
            if (acc[2]) dw_data_addr_valid = 1'b0;
            pend &= ~acc;
            budget++;
        end
        check("accept_all", 64'(pend), 64'd0);
        wait_drain("batch_drain");
    endtask

    // Memory responder: random request stall, random response latency
    task automatic mem_serve();
        logic [31:0] a;
        logic        fired;
        int          stall;
        int          guard;
        stall = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
        force_stall = -1;
        repeat (stall) begin @(posedge clk); #1; end
        m_req_ready = 1'b1;
        a = m_req_addr;
        @(posedge clk); #1;
        m_req_ready = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        m_rsp_valid = 1'b1;
        m_rsp_rdata = mem_rdata(a);
        m_rsp_resp  = mem_resp(a);
        fired = 1'b0;
        guard = 0;
        while (!fired && guard < 200) begin
            @(negedge clk);
            fired = m_rsp_ready;
            @(posedge clk); #1;
            guard++;
        end
        m_rsp_valid = 1'b0;
        m_rsp_rdata = '0;
        m_rsp_resp  = '0;
        if (!fired) check("mem_rsp_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        m_req_ready = 1'b0;
        m_rsp_valid = 1'b0;
        m_rsp_rdata = '0;
        m_rsp_resp  = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_auto && !rst && m_req_valid) mem_serve();
        end
    end

    // Random upstream response backpressure
    initial begin
        ir_data_ready = 1'b0;
        dr_data_ready = 1'b0;
        dw_resp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rdy_auto) begin
                ir_data_ready = 1'($urandom_range(0, 1));
                dr_data_ready = 1'($urandom_range(0, 1));
                dw_resp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a handshake
    bit          resp_phase = 1'b0;
    bit          prev_hold  = 1'b0;
    logic [36:0] prev_ctl;
    logic [31:0] prev_wdata;

    always @(negedge clk) begin
        logic [2:0] rdy, rv, urdy, oh;
        logic [1:0] exp_ch;
        txn_t       t;
        if (rst) begin
            resp_phase = 1'b0;
            prev_hold  = 1'b0;
        end else begin
            rdy  = {dw_data_addr_ready, dr_addr_ready, ir_addr_ready};
            rv   = {dw_resp_valid, dr_data_valid, ir_data_valid};
            urdy = {dw_resp_ready, dr_data_ready, ir_data_ready};

            if (resp_phase && rsp_q.size() != 0) begin
                t  = rsp_q[0];
                oh = 3'b001 << t.ch;
                check("rsp_ready_route", 64'(m_rsp_ready), 64'(urdy[t.ch]));
                check("rsp_valid_route", 64'(rv), m_rsp_valid ? 64'(oh) : 64'd0);
                if (m_rsp_valid && m_rsp_ready) begin
                    void'(rsp_q.pop_front());
                    if (t.ch == 2'd2) check("dw_resp", 64'(dw_resp), 64'(t.resp));
                    else if (t.ch == 2'd1) check("dr_data", 64'(dr_data), 64'(t.rdata));
                    else check("ir_data", 64'(ir_data), 64'(t.rdata));
                    resp_phase = 1'b0;
                end
            end else begin
                check("rsp_quiet", 64'({m_rsp_ready, rv}), 64'd0);
            end

            if (rdy != 3'b000) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_accept", 64'(rdy), 64'd0);
                end else begin
                    exp_ch = acc_q.pop_front();
                    oh = 3'b001 << exp_ch;
                    check("accept_grant", 64'(rdy), 64'(oh));
                end
            end

            if (m_req_valid) begin
                check("no_ready_in_req", 64'(rdy), 64'd0);
                if (prev_hold) begin
                    check("req_stable_ctl", 64'({m_req_we, m_req_strobe, m_req_addr}), 64'(prev_ctl));
                    check("req_stable_wdata", 64'(m_req_wdata), 64'(prev_wdata));
                end
                if (m_req_ready) begin
                    if (req_q.size() == 0) begin
                        check("unexpected_req", 64'd1, 64'd0);
                    end else begin
                        t = req_q.pop_front();
                        check("req_addr", 64'(m_req_addr), 64'(t.addr));
                        check("req_we", 64'(m_req_we), 64'(t.we));
                        check("req_wdata", 64'(m_req_wdata), 64'(t.wdata));
                        check("req_strobe", 64'(m_req_strobe), 64'(t.strobe));
                    end
                    resp_phase = 1'b1;
                    prev_hold  = 1'b0;
                end else begin
                    prev_hold  = 1'b1;
                    prev_ctl   = {m_req_we, m_req_strobe, m_req_addr};
                    prev_wdata = m_req_wdata;
                end
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    task automatic reset_test();
        int guard;
        mem_auto = 1'b0;
        rdy_auto = 1'b0;
        @(posedge clk); #1;
        ir_data_ready = 1'b1;
        dr_data_ready = 1'b0;
        dw_resp_ready = 1'b1;
        set_slot(2'd1, 32'h0000_2468, 32'h0, 4'h0);
        model_push(3'b010);
        dr_addr_valid = 1'b1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!dr_addr_ready && guard < 50);
        check("rst_seq_accept", 64'(dr_addr_ready), 64'd1);
        @(posedge clk); #1;
        check("rst_seq_req_valid", 64'(m_req_valid), 64'd1);
        m_req_ready = 1'b1;
        @(posedge clk); #1;
        m_req_ready = 1'b0;
        m_rsp_valid = 1'b1;
        m_rsp_rdata = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        m_rsp_valid = 1'b0;
        m_rsp_rdata = '0;
        #1;
        check("rst_async_ctl", 64'({ir_addr_ready, dr_addr_ready, dw_data_addr_ready,
                                    ir_data_valid, dr_data_valid, dw_resp_valid,
                                    m_req_valid, m_rsp_ready}), 64'd0);
        check("rst_async_payload", 64'({m_req_we, m_req_strobe, m_req_addr}), 64'd0);
        check("rst_async_wdata", 64'(m_req_wdata), 64'd0);
        rsp_q.delete();
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        model_last = 2;
`endif
        model_push(3'b010);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_accept", 64'(dr_addr_ready), 64'd1);
        @(posedge clk); #1;
        dr_addr_valid = 1'b0;
        mem_auto = 1'b1;
        rdy_auto = 1'b1;
        wait_drain("rst_seq_drain");
    endtask

    initial begin
        rst = 1'b1;
        ir_addr_valid = 1'b0; dr_addr_valid = 1'b0; dw_data_addr_valid = 1'b0;
        ir_addr = '0; dr_addr = '0; dw_addr = '0; dw_data = '0; dw_strobe = '0;
        repeat (2) @(posedge clk); #1;
        ir_addr_valid = 1'b1;
        #1;
        check("reset_readies", 64'({ir_addr_ready, dr_addr_ready, dw_data_addr_ready}), 64'd0);
        check("reset_rsp", 64'({ir_data_valid, dr_data_valid, dw_resp_valid, m_rsp_ready}), 64'd0);
        check("reset_req", 64'({m_req_valid, m_req_we, m_req_strobe, m_req_addr}), 64'd0);
        check("reset_wdata", 64'(m_req_wdata), 64'd0);
        ir_addr_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        set_slot(2'd0, 32'h0000_0100, 32'h0, 4'h0);
        run_batch(3'b001);

        for (int r = 0; r < 2; r++) begin
            set_slot(2'd0, 32'h0000_1000, 32'h0, 4'h0);
            set_slot(2'd1, 32'h0000_2000, 32'h0, 4'h0);
            set_slot(2'd2, 32'h0000_2004, 32'hCAFE_F00D, 4'hF);
            run_batch(3'b111);
        end

        for (int b = 0; b < 40; b++) begin
            logic [2:0] mask;
            mask = 3'($urandom_range(1, 7));
            for (int c = 0; c < 3; c++) begin
                if (mask[c]) set_slot(2'(c), $urandom, $urandom, 4'($urandom_range(0, 15)));
            end
            run_batch(mask);
        end

        reset_test();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at t=%0t, required to finish earlier", $time);
        $fatal(1);
    end

endmodule
